// File: rtl/bitplane_dma.sv
// bitplane_dma -- bitplane DMA slot sequencer.
// For every bus slot it decides whether one of up to six bitplanes is
// fetched. The decision taken on hpos in cycle N appears on the registered
// outputs in cycle N+1.
// Ports:
//   clk            chipset bus clock, one clock per DMA slot
//   _reset         asynchronous active-low reset
//   hpos           horizontal beam position in slots (0..226, wraps)
//   vwindow        vertical bitplane window active for this line
//   dmaen          DMACON DMAEN & BPLEN
//   regaddress_in  [8:1] address of the current bus register write
//   datain         bus write data
//   dma            slot used by bitplane DMA
//   address_out    [20:1] chip-RAM word address of the fetch
//   regaddress_out [8:1] BPLxDAT destination, 8'hFF when the slot is free

// Per-plane pointer: a bus write of either half takes priority over the DMA
// increment arriving in the same cycle.
module bitplane_dma_ptr (
  input  logic        clk,
  input  logic        _reset,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [15:0] datain,
  input  logic        inc_en,
  input  logic [19:0] inc,
  output logic [19:0] ptr
);
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset)     ptr <= '0;
    else if (wr_hi)  ptr[19:15] <= datain[4:0];
    else if (wr_lo)  ptr[14:0]  <= datain[15:1];
    else if (inc_en) ptr <= ptr + inc;
  end
endmodule

module bitplane_dma (
  input  logic        clk,
  input  logic        _reset,
  input  logic [8:0]  hpos,
  input  logic        vwindow,
  input  logic        dmaen,
  input  logic [8:1]  regaddress_in,
  input  logic [15:0] datain,
  output logic        dma,
  output logic [20:1] address_out,
  output logic [8:1]  regaddress_out
);
  localparam int        NUM_PLANES = 6;
  localparam logic [7:0] R_DDFSTRT = 8'h49;  // 0x092
  localparam logic [7:0] R_DDFSTOP = 8'h4A;  // 0x094
  localparam logic [7:0] R_BPLCON0 = 8'h80;  // 0x100
  localparam logic [7:0] R_BPL1MOD = 8'h84;  // 0x108
  localparam logic [7:0] R_BPL2MOD = 8'h85;  // 0x10A
  localparam logic [7:0] R_BPLPT   = 8'h70;  // 0x0E0
  localparam logic [7:0] R_BPLDAT  = 8'h88;  // 0x110

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_e;

  state_e      state;
  logic [2:0]  phase;
  logic [6:0]  ddfstrt, ddfstop;
  logic        con_hires, u_hires, cur_hires;
  logic [2:0]  con_bpu, u_bpu, cur_bpu, eff;
  logic [19:0] mod1, mod2, inc, fetch_addr;
  logic [2:0]  ph, plane;
  logic        start, go, last_unit, unit_end, fetch;
  logic [NUM_PLANES-1:0][19:0] ptrs;

  // Control registers written from the bus.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ddfstrt   <= '0;
      ddfstop   <= '0;
      con_hires <= 1'b0;
      con_bpu   <= '0;
      mod1      <= '0;
      mod2      <= '0;
    end else begin
      case (regaddress_in)
        R_DDFSTRT: ddfstrt <= datain[7:1];
        R_DDFSTOP: ddfstop <= datain[7:1];
        R_BPLCON0: begin
          con_hires <= datain[15];
          con_bpu   <= datain[14:12];
        end
        R_BPL1MOD: mod1 <= {{5{datain[15]}}, datain[15:1]};
        R_BPL2MOD: mod2 <= {{5{datain[15]}}, datain[15:1]};
        default: ;
      endcase
    end
  end

  // Slot decision for the current hpos.
  always_comb begin
    // The matching DDFSTRT slot is already phase 0 of the first unit.
    ph = (state == IDLE) ? 3'd0 : phase;
    // BPLCON0 is sampled only at unit start so a unit never changes shape.
    cur_hires = (ph == 3'd0) ? con_hires : u_hires;
    cur_bpu   = (ph == 3'd0) ? con_bpu   : u_bpu;
    if (cur_hires) eff = (cur_bpu > 3'd4) ? 3'd4 : cur_bpu;
    else           eff = (cur_bpu > 3'd6) ? 3'd6 : cur_bpu;

    plane = 3'd0;
    if (cur_hires) begin
      case (ph[1:0])
        2'd0:    plane = 3'd4;
        2'd1:    plane = 3'd2;
        2'd2:    plane = 3'd3;
        default: plane = 3'd1;
      endcase
    end else begin
      case (ph)
        3'd1:    plane = 3'd4;
        3'd2:    plane = 3'd6;
        3'd3:    plane = 3'd2;
        3'd5:    plane = 3'd3;
        3'd6:    plane = 3'd5;
        3'd7:    plane = 3'd1;
        default: plane = 3'd0;
      endcase
    end

    unit_end  = cur_hires ? (ph[1:0] == 2'd3) : (ph == 3'd7);
    start     = !hpos[8] && (hpos[7:0] == {ddfstrt, 1'b0}) && vwindow && dmaen;
    // Losing dmaen/vwindow or the line wrapping abandons the line outright.
    go        = (state == IDLE) ? start : (vwindow && dmaen && (hpos != 9'd0));
    last_unit = (state == LAST) || ((ph == 3'd0) && (hpos[7:0] >= {ddfstop, 1'b0}));
    fetch     = go && (plane != 3'd0) && (plane <= eff);
    // Each plane is fetched once in the final unit, so adding the modulo
    // there applies it exactly once per line.
    inc       = last_unit ? (20'd1 + (plane[0] ? mod1 : mod2)) : 20'd1;

    fetch_addr = '0;
    for (int i = 0; i < NUM_PLANES; i++)
      if (plane == 3'(i + 1)) fetch_addr = ptrs[i];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLANES; gi++) begin : g_ptr
      bitplane_dma_ptr u_ptr (
        .clk    (clk),
        ._reset (_reset),
        .wr_hi  (regaddress_in == R_BPLPT + 8'(2 * gi)),
        .wr_lo  (regaddress_in == R_BPLPT + 8'(2 * gi + 1)),
        .datain (datain),
        .inc_en (fetch && (plane == 3'(gi + 1))),
        .inc    (inc),
        .ptr    (ptrs[gi])
      );
    end
  endgenerate

  // Sequencer state and registered slot outputs.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state          <= IDLE;
      phase          <= '0;
      u_hires        <= 1'b0;
      u_bpu          <= '0;
      dma            <= 1'b0;
      address_out    <= '0;
      regaddress_out <= 8'hFF;
    end else begin
      dma            <= fetch;
      regaddress_out <= fetch ? (R_BPLDAT + {5'd0, plane - 3'd1}) : 8'hFF;
      if (fetch) address_out <= fetch_addr;

      if (ph == 3'd0) begin
        u_hires <= con_hires;
        u_bpu   <= con_bpu;
      end

      if (!go) begin
        state <= IDLE;
        phase <= '0;
      end else if (unit_end) begin
        state <= last_unit ? IDLE : FETCH;
        phase <= '0;
      end else begin
        state <= last_unit ? LAST : FETCH;
        phase <= ph + 3'd1;
      end
    end
  end
endmodule
